// File: rtl/game_flow.sv
// Top-level game sequencer: title screen, team selection of three distinct
// pokemon, the initiating side of the battle handshake, and win/lose screens.
// Every output is a register; the next value of each one is formed in a single
// combinational block and loaded on the clock edge.
module game_flow #(
  parameter int          NUM_MONS       = 8,
  parameter int          RESULT_TIMEOUT = 50_000_000,
  parameter logic [7:0]  KEY_W          = 8'h1A,
  parameter logic [7:0]  KEY_A          = 8'h04,
  parameter logic [7:0]  KEY_S          = 8'h16,
  parameter logic [7:0]  KEY_D          = 8'h07,
  parameter logic [7:0]  KEY_ENTER      = 8'h28,
  parameter logic [7:0]  KEY_BKSP       = 8'h2A
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] keycode,
  input  logic       end_battle,
  input  logic       result,
  output logic       is_battle,
  output logic [8:0] team,
  output logic [2:0] screen,
  output logic [2:0] cursor,
  output logic [7:0] picked_mask,
  output logic [1:0] pick_count,
  output logic [7:0] win_streak
);

  typedef enum logic [2:0] {
    S_TITLE  = 3'd0,
    S_SELECT = 3'd1,
    S_BATTLE = 3'd2,
    S_WIN    = 3'd3,
    S_LOSE   = 3'd4
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [7:0]  prev_key;
  logic [31:0] cnt;
  logic [31:0] cnt_n;
  logic        is_battle_n;
  logic [8:0]  team_n;
  logic [2:0]  cursor_n;
  logic [7:0]  mask_n;
  logic [1:0]  count_n;
  logic [7:0]  streak_n;
  logic        press;
  int          slot;

  // A key acts once: only the first cycle of a new non-zero keycode is a press.
  assign press  = (keycode != 8'd0) && (keycode != prev_key);
  assign screen = state;

  // Next-state and next-output logic for the whole sequencer.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    is_battle_n = is_battle;
    team_n      = team;
    cursor_n    = cursor;
    mask_n      = picked_mask;
    count_n     = pick_count;
    streak_n    = win_streak;
    slot        = 0;

    case (state)
      S_TITLE: begin
        if (press && keycode == KEY_ENTER) begin
          state_n  = S_SELECT;
          team_n   = '0;
          mask_n   = '0;
          count_n  = '0;
          cursor_n = '0;
        end
      end

      S_SELECT: begin
        if (press) begin
          // Grid is 4 wide: row = cursor[2], column = cursor[1:0]; no wrapping.
          if (keycode == KEY_W) begin
            if (cursor[2]) cursor_n = cursor - 3'd4;
          end else if (keycode == KEY_S) begin
            if (!cursor[2] && (int'(cursor) + 4 < NUM_MONS)) cursor_n = cursor + 3'd4;
          end else if (keycode == KEY_A) begin
            if (cursor[1:0] != 2'd0) cursor_n = cursor - 3'd1;
          end else if (keycode == KEY_D) begin
            if ((cursor[1:0] != 2'd3) && (int'(cursor) + 1 < NUM_MONS)) cursor_n = cursor + 3'd1;
          end else if (keycode == KEY_ENTER) begin
            if (!picked_mask[cursor]) begin
              slot                 = int'(pick_count);
              team_n[slot*3 +: 3]  = cursor;
              mask_n[cursor]       = 1'b1;
              count_n              = pick_count + 2'd1;
              // The third pick starts the battle on this same edge.
              if (pick_count == 2'd2) begin
                state_n     = S_BATTLE;
                is_battle_n = 1'b1;
              end
            end
          end else if (keycode == KEY_BKSP) begin
            if (pick_count != 2'd0) begin
              slot                        = int'(pick_count) - 1;
              mask_n[team[slot*3 +: 3]]   = 1'b0;
              team_n[slot*3 +: 3]         = 3'd0;
              count_n                     = pick_count - 2'd1;
            end else begin
              state_n = S_TITLE;
            end
          end
        end
      end

      S_BATTLE: begin
        // Team is frozen and keys are ignored until the engine reports back.
        is_battle_n = 1'b1;
        if (end_battle) begin
          is_battle_n = 1'b0;
          cnt_n       = '0;
          if (result) begin
            state_n = S_WIN;
            if (win_streak != 8'hFF) streak_n = win_streak + 8'd1;
          end else begin
            state_n  = S_LOSE;
            streak_n = 8'd0;
          end
        end
      end

      S_WIN, S_LOSE: begin
        cnt_n = cnt + 32'd1;
        if ((press && keycode == KEY_ENTER) || (cnt == 32'(RESULT_TIMEOUT - 1))) begin
          state_n  = S_TITLE;
          team_n   = '0;
          mask_n   = '0;
          count_n  = '0;
          cursor_n = '0;
        end
      end

      default: begin
        state_n     = S_TITLE;
        is_battle_n = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= S_TITLE;
      prev_key    <= 8'd0;
      cnt         <= '0;
      is_battle   <= 1'b0;
      team        <= '0;
      cursor      <= '0;
      picked_mask <= '0;
      pick_count  <= '0;
      win_streak  <= '0;
    end else begin
      state       <= state_n;
      prev_key    <= keycode;
      cnt         <= cnt_n;
      is_battle   <= is_battle_n;
      team        <= team_n;
      cursor      <= cursor_n;
      picked_mask <= mask_n;
      pick_count  <= count_n;
      win_streak  <= streak_n;
    end
  end

endmodule
